lbm_boundary_scanner: RTL and testbench
=======================================

// Module: lbm_boundary_scanner
// PURPOSE
//  Sequential grid walker for the LBM lid-driven-cavity pipeline. On a start pulse it
//  scans every node of an NX x NY grid, one node per handshake. For each node it emits
//  the coordinates plus a one-hot boundary class (LID/BOTTOM/LEFT/RIGHT/FLUID) and
//  accumulates a wall-node count. It feeds the streaming/bounce-back stage via valid/ready.
// PARAMETERS
//  NX    16            grid extent along x (lid at x==NX-1, bottom at x==0); NX>=3
//  NY    16            grid extent along y (left at y==0, right at y==NY-1); NY>=3
//  X_W   $clog2(NX)    x coordinate width
//  Y_W   $clog2(NY)    y coordinate width
//  CNT_W $clog2(NX*NY+1) wall counter width
// PORTS
//  clk         in   1      single clock, all logic rising-edge
//  reset       in   1      synchronous, active-high
//  start       in   1      begin scan; honoured only in IDLE
//  out_ready   in   1      downstream accepts current node
//  out_valid   out  1      node outputs valid
//  out_x       out  X_W    node x coordinate
//  out_y       out  Y_W    node y coordinate
//  lid         out  1      class flags, one-hot with fluid while out_valid
//  bottom_wall out  1
//  left_wall   out  1
//  right_wall  out  1
//  fluid       out  1      interior node
//  busy        out  1      high in SCAN
//  done        out  1      one-cycle pulse after last node accepted
//  wall_count  out  CNT_W  non-fluid nodes accepted this scan; held until next start
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; out_valid=0, busy=0, done=0, out_x=0, out_y=0,
//    all class flags=0, wall_count=0. Reset mid-scan aborts immediately with no done pulse.
//  - FSM: IDLE --start--> SCAN --last handshake--> DONE --(1 cycle)--> IDLE. start ignored
//    outside IDLE.
//  - Start accepted at cycle N: x=y=0, wall_count cleared, busy=1. out_valid=1 from cycle N+1.
//  - Scan order: x inner 0..NX-1, y outer 0..NY-1. Handshake = out_valid & out_ready advances.
//    x wraps NX-1->0 with y+1. Full-rate: 1 node/cycle with ready held high.
//  - Outputs are registered and held stable while out_valid & !out_ready. No bubbles inserted.
//  - Classification, from the registered coordinates, strict priority:
//    lid:    x==NX-1 && 1<=y<=NY-2
//    bottom: x==0
//    left:   y==0
//    right:  y==NY-1
//    fluid:  otherwise
//  - Corners therefore resolve as follows: (0,*) is bottom; (NX-1,0) is left; (NX-1,NY-1) is right.
//  - Exactly one flag is high while out_valid. All flags are 0 when !out_valid.
//  - wall_count increments on each handshake of a non-fluid node. It saturates at
//    2^CNT_W-1, which is never reached for legal params.
//  - Last node (NX-1,NY-1) handshake at cycle M: out_valid=0, busy=0, done=1 at M+1 (DONE).
//    The FSM is back in IDLE at M+2. A start at M+1 is ignored.
//  - Total handshakes per scan = NX*NY. Final wall_count = 2*NX+2*NY-4.
// CONFIGURATION
//  LBM_CORNER_EN defined: adds output port `corner` (1 bit). It is high with out_valid when
//    (x==0||x==NX-1)&&(y==0||y==NY-1). It is held and reset like the flags. Class flags are
//    unchanged.
//  LBM_CORNER_EN undefined: no corner port and no corner logic. All other behaviour is identical.
// TESTING (NX=NY=16 unless noted)
//  1. reset, start pulse, out_ready=1 -> 256 handshakes in order, done at 257th cycle after
//     out_valid rises, wall_count=60.
//  2. Spot classes: (15,7)->lid; (0,0)->bottom; (0,15)->bottom; (15,0)->left;
//     (15,15)->right; (5,15)->right; (7,7)->fluid.
//  3. Backpressure: out_ready toggles 1,0,0,1 -> outputs are stable through stall cycles,
//     no node is skipped or duplicated, and the final count is still 60.
//  4. Reset asserted at node (3,4) -> next cycle out_valid=0, busy=0, no done. A new start
//     restarts at (0,0) with wall_count=0.
//  5. start asserted during SCAN and at DONE -> ignored, so the scan and count are unchanged.
//  6. NX=4, NY=3 with LBM_CORNER_EN -> 12 nodes, wall_count=10, corner high only at
//     (0,0), (3,0), (0,2), (3,2).

Source files
------------

// File: rtl/lbm_boundary_scanner.sv
// lbm_boundary_scanner: walks an NX x NY lattice one node per valid/ready
// handshake, tagging each node with a one-hot boundary class for the
// lid-driven-cavity bounce-back stage and counting wall nodes.
// Optional feature macro: LBM_CORNER_EN adds a registered `corner` output.
`timescale 1ns/1ps

module lbm_boundary_scanner #(
  parameter int NX    = 16,
  parameter int NY    = 16,
  parameter int X_W   = $clog2(NX),
  parameter int Y_W   = $clog2(NY),
  parameter int CNT_W = $clog2(NX*NY+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic             lid,
  output logic             bottom_wall,
  output logic             left_wall,
  output logic             right_wall,
  output logic             fluid,
  output logic             busy,
  output logic             done,
`ifdef LBM_CORNER_EN
  output logic             corner,
`endif
  output logic [CNT_W-1:0] wall_count
);

  // Handshake: a node transfers on any rising edge where out_valid && out_ready.
  // While out_valid is high and out_ready low, every node output is held.
  // out_valid never drops before its node has transferred.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0]   X_LAST  = X_W'(NX - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(NY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t         state;
  // Class vector ordered {lid, bottom, left, right, fluid}.
  logic [4:0]     cls;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;
  logic           last_node;

  // Strict-priority classification: lid first, so the lid row excludes the
  // two top corners, which fall through to left/right.
  function automatic logic [4:0] classify(input logic [X_W-1:0] cx,
                                          input logic [Y_W-1:0] cy);
    logic [4:0] c;
    if (cx == X_LAST && cy != '0 && cy != Y_LAST) c = 5'b10000;
    else if (cx == '0)                            c = 5'b01000;
    else if (cy == '0)                            c = 5'b00100;
    else if (cy == Y_LAST)                        c = 5'b00010;
    else                                          c = 5'b00001;
    return c;
  endfunction

`ifdef LBM_CORNER_EN
  function automatic logic is_corner(input logic [X_W-1:0] cx,
                                     input logic [Y_W-1:0] cy);
    return (cx == '0 || cx == X_LAST) && (cy == '0 || cy == Y_LAST);
  endfunction
`endif

  // Next coordinate in raster order: x inner, y outer.
  always_comb begin
    next_x    = out_x + 1'b1;
    next_y    = out_y;
    last_node = (out_x == X_LAST) && (out_y == Y_LAST);
    if (out_x == X_LAST) begin
      next_x = '0;
      next_y = out_y + 1'b1;
    end
  end

  // Scan FSM with all node outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      cls        <= '0;
      wall_count <= '0;
`ifdef LBM_CORNER_EN
      corner     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SCAN;
            out_x      <= '0;
            out_y      <= '0;
            wall_count <= '0;
            busy       <= 1'b1;
            out_valid  <= 1'b1;
            cls        <= classify('0, '0);
`ifdef LBM_CORNER_EN
            corner     <= 1'b1;
`endif
          end
        end
        SCAN: begin
          if (out_valid && out_ready) begin
            if (!cls[0] && wall_count != CNT_MAX) wall_count <= wall_count + 1'b1;
            if (last_node) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cls       <= '0;
`ifdef LBM_CORNER_EN
              corner    <= 1'b0;
`endif
            end else begin
              out_x <= next_x;
              out_y <= next_y;
              cls   <= classify(next_x, next_y);
`ifdef LBM_CORNER_EN
              corner <= is_corner(next_x, next_y);
`endif
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lid         = cls[4];
  assign bottom_wall = cls[3];
  assign left_wall   = cls[2];
  assign right_wall  = cls[1];
  assign fluid       = cls[0];

endmodule

// File: tb/tb_lbm_boundary_scanner.sv
// Directed bench for lbm_boundary_scanner: a 16x16 instance for the main
// scenarios and a 4x3 instance for the small-grid / corner scenario.
`timescale 1ns/1ps

module tb_lbm_boundary_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16x16 instance
  logic       start, out_ready, out_valid, busy, done;
  logic [3:0] out_x, out_y;
  logic       lid, bottom_wall, left_wall, right_wall, fluid;
  logic [8:0] wall_count;
`ifdef LBM_CORNER_EN
  logic       corner;
`endif

  // 4x3 instance
  logic       s_start, s_ready, s_valid, s_busy, s_done;
  logic [1:0] s_x, s_y;
  logic       s_lid, s_bottom, s_left, s_right, s_fluid;
  logic [3:0] s_wc;
`ifdef LBM_CORNER_EN
  logic       s_corner;
`endif

  lbm_boundary_scanner #(.NX(16), .NY(16)) dut (
    .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .lid(lid), .bottom_wall(bottom_wall), .left_wall(left_wall),
    .right_wall(right_wall), .fluid(fluid), .busy(busy), .done(done),
`ifdef LBM_CORNER_EN
    .corner(corner),
`endif
    .wall_count(wall_count)
  );

  lbm_boundary_scanner #(.NX(4), .NY(3)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .out_ready(s_ready),
    .out_valid(s_valid), .out_x(s_x), .out_y(s_y),
    .lid(s_lid), .bottom_wall(s_bottom), .left_wall(s_left),
    .right_wall(s_right), .fluid(s_fluid), .busy(s_busy), .done(s_done),
`ifdef LBM_CORNER_EN
    .corner(s_corner),
`endif
    .wall_count(s_wc)
  );

  // Reference classification {lid, bottom, left, right, fluid}
  function automatic logic [4:0] exp_class(input int x, input int y,
                                           input int nx, input int ny);
    if (x == nx - 1 && y >= 1 && y <= ny - 2) return 5'b10000;
    if (x == 0)      return 5'b01000;
    if (y == 0)      return 5'b00100;
    if (y == ny - 1) return 5'b00010;
    return 5'b00001;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_x !== 4'd0 || out_y !== 4'd0 ||
        wall_count !== 9'd0 || bottom_wall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start: got valid=%b busy=%b x=%0d y=%0d wc=%0d bottom=%b done=%b, expected 1 1 0 0 0 1 0",
               out_valid, busy, out_x, out_y, wall_count, bottom_wall, done);
    end
  endtask

  // Consumes a full scan from the current negedge (node (0,0) showing).
  task automatic run_scan(input bit bp, input bit poke_start, input string name);
    int         hs, ecount, cyc, ex, ey;
    logic       stall, ready;
    logic [3:0] pat;
    logic [12:0] held;
    logic [4:0] f;
    hs = 0; ecount = 0; cyc = 0; ex = 0; ey = 0; stall = 1'b0; pat = 4'b1001; held = '0;
    while (hs < 256 && cyc < 2000) begin
      f = {lid, bottom_wall, left_wall, right_wall, fluid};
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_x !== 4'(ex) || out_y !== 4'(ey) ||
          f !== exp_class(ex, ey, 16, 16) || wall_count !== 9'(ecount)) begin
        errors++;
        $display("FAIL %s node: got valid=%b x=%0d y=%0d cls=%b wc=%0d, expected valid=1 x=%0d y=%0d cls=%b wc=%0d",
                 name, out_valid, out_x, out_y, f, wall_count, ex, ey, exp_class(ex, ey, 16, 16), ecount);
      end
      if (stall) begin
        checks++;
        if ({out_x, out_y, f} !== held) begin
          errors++;
          $display("FAIL %s stall hold: got %h, expected %h", name, {out_x, out_y, f}, held);
        end
      end
      ready     = bp ? pat[cyc % 4] : 1'b1;
      out_ready = ready;
      start     = poke_start && (cyc % 37 == 5);
      held      = {out_x, out_y, f};
      stall     = !ready;
      if (ready) begin
        hs++;
        if (exp_class(ex, ey, 16, 16) != 5'b00001) ecount++;
        if (ex == 15) begin ex = 0; ey++; end else ex++;
      end
      cyc++;
      @(negedge clk);
    end
    // Now in DONE; a start here must be ignored.
    start = poke_start;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || wall_count !== 9'd60 ||
        ecount != 60 || hs != 256) begin
      errors++;
      $display("FAIL %s end: got done=%b valid=%b busy=%b wc=%0d hs=%0d, expected done=1 valid=0 busy=0 wc=60 hs=256",
               name, done, out_valid, busy, wall_count, hs);
    end
    if (!bp) begin
      checks++;
      if (cyc != 256) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, expected 256", name, cyc);
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || wall_count !== 9'd60) begin
      errors++;
      $display("FAIL %s idle: got done=%b valid=%b busy=%b wc=%0d, expected 0 0 0 60",
               name, done, out_valid, busy, wall_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_x !== 4'd0 ||
        out_y !== 4'd0 || {lid, bottom_wall, left_wall, right_wall, fluid} !== 5'b0 ||
        wall_count !== 9'd0) begin
      errors++;
      $display("FAIL reset: got valid=%b busy=%b done=%b x=%0d y=%0d cls=%b wc=%0d, expected all 0",
               out_valid, busy, done, out_x, out_y,
               {lid, bottom_wall, left_wall, right_wall, fluid}, wall_count);
    end
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_wc !== 4'd0 ||
        {s_lid, s_bottom, s_left, s_right, s_fluid} !== 5'b0) begin
      errors++;
      $display("FAIL reset small: got valid=%b busy=%b done=%b wc=%0d, expected all 0",
               s_valid, s_busy, s_done, s_wc);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle hold: got valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_full_rate();
    do_start();
    run_scan(1'b0, 1'b0, "full_rate");
  endtask

  task automatic test_spot_classes();
    int         sx[7];
    int         sy[7];
    logic [4:0] sf[7];
    int         found, cyc;
    sx = '{15, 0, 0, 15, 15, 5, 7};
    sy = '{7, 0, 15, 0, 15, 15, 7};
    sf = '{5'b10000, 5'b01000, 5'b01000, 5'b00100, 5'b00010, 5'b00010, 5'b00001};
    found = 0; cyc = 0;
    do_start();
    out_ready = 1'b1;
    while (!done && cyc < 300) begin
      if (out_valid) begin
        for (int k = 0; k < 7; k++) begin
          if (out_x == 4'(sx[k]) && out_y == 4'(sy[k])) begin
            found++;
            checks++;
            if ({lid, bottom_wall, left_wall, right_wall, fluid} !== sf[k]) begin
              errors++;
              $display("FAIL spot (%0d,%0d): got %b, expected %b", sx[k], sy[k],
                       {lid, bottom_wall, left_wall, right_wall, fluid}, sf[k]);
            end
          end
        end
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || found != 7) begin
      errors++;
      $display("FAIL spot coverage: got done=%b found=%0d, expected done=1 found=7", done, found);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_start();
    run_scan(1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_start_ignored();
    do_start();
    run_scan(1'b0, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    cyc = 0;
    do_start();
    out_ready = 1'b1;
    while (!(out_valid === 1'b1 && out_x == 4'd3 && out_y == 4'd4) && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (out_x !== 4'd3 || out_y !== 4'd4) begin
      errors++;
      $display("FAIL mid reach: got x=%0d y=%0d, expected x=3 y=4", out_x, out_y);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wall_count !== 9'd0 ||
        out_x !== 4'd0 || out_y !== 4'd0) begin
      errors++;
      $display("FAIL mid reset: got valid=%b busy=%b done=%b wc=%0d x=%0d y=%0d, expected 0 0 0 0 0 0",
               out_valid, busy, done, wall_count, out_x, out_y);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort quiet: got done=%b valid=%b, expected 0 0", done, out_valid);
      end
    end
    do_start();
    run_scan(1'b0, 1'b0, "restart");
  endtask

  task automatic test_small_grid();
    int n, ex, ey;
    logic [4:0] f;
    n = 0;
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (s_valid === 1'b1 && n < 20) begin
      ex = n % 4;
      ey = n / 4;
      f  = {s_lid, s_bottom, s_left, s_right, s_fluid};
      checks++;
      if (s_x !== 2'(ex) || s_y !== 2'(ey) || f !== exp_class(ex, ey, 4, 3)) begin
        errors++;
        $display("FAIL small node %0d: got x=%0d y=%0d cls=%b, expected x=%0d y=%0d cls=%b",
                 n, s_x, s_y, f, ex, ey, exp_class(ex, ey, 4, 3));
      end
`ifdef LBM_CORNER_EN
      checks++;
      if (s_corner !== ((ex == 0 || ex == 3) && (ey == 0 || ey == 2))) begin
        errors++;
        $display("FAIL small corner (%0d,%0d): got %b", ex, ey, s_corner);
      end
`endif
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 12 || s_done !== 1'b1 || s_wc !== 4'd10) begin
      errors++;
      $display("FAIL small end: got nodes=%0d done=%b wc=%0d, expected nodes=12 done=1 wc=10",
               n, s_done, s_wc);
    end
`ifdef LBM_CORNER_EN
    checks++;
    if (s_corner !== 1'b0) begin
      errors++;
      $display("FAIL small corner idle: got %b, expected 0", s_corner);
    end
`endif
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_rate();
    test_spot_classes();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_scan();
    test_small_grid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
